tt_mem_byte_bridge: RTL and testbench

Parametrised byte-serial memory bridge between the RISC-V core's internal request/response bus and the 8-bit Tiny Tapeout pins.

- Each accepted core request is serialised as a header byte, address bytes and optional write-data bytes on the dedicated outputs.
- Read data returns byte-by-byte on the dedicated inputs and is reassembled into a full word.
- Sits inside `tt_um_emmk_riscv`, between the core's load/store/fetch port and `uo_out`/`ui_in`/`uio_*`.
- Successor to the fixed 8-bit pin wiring: width, address size and response timeout are generic.

---
 rtl/tt_mem_byte_bridge.sv | 240 ++++++++++++++++++++++++
 tb/tb_tt_mem_byte_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_mem_byte_bridge.sv
// ============================================================================
// Module  : tt_mem_byte_bridge
// Purpose : Byte-serial bridge from the core request/response bus to 8-bit pins.
//           Optional read timeout is enabled by defining TT_BRIDGE_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_mem_byte_bridge #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        pin_out,
    output logic              pin_strobe,
    input  logic [7:0]        pin_in,
    input  logic              pin_in_valid
);

    localparam int          c_NA      = ADDR_W / 8;
    localparam int          c_ND      = DATA_W / 8;
    localparam int          c_NMAX    = (c_NA > c_ND) ? c_NA : c_ND;
    localparam int          c_CW      = $clog2(c_NMAX + 1);
    localparam logic [3:0]  c_HDR_LEN = 4'(c_ND - 1);

    generate
        if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 128) begin : g_bad_data_w
            $error("tt_mem_byte_bridge: DATA_W must be a multiple of 8 in 8..128");
        end
        if ((ADDR_W % 8) != 0 || ADDR_W < 8 || ADDR_W > 32) begin : g_bad_addr_w
            $error("tt_mem_byte_bridge: ADDR_W must be a multiple of 8 in 8..32");
        end
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("tt_mem_byte_bridge: TIMEOUT must be in 1..65535");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        ADDR  = 3'd2,
        WDATA = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [c_CW-1:0]     cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic                tmo_hit;

    logic [7:0]          pin_out_q, pin_out_d;
    logic                pin_strobe_q, pin_strobe_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef TT_BRIDGE_TIMEOUT_EN
    localparam int       c_TW = $clog2(TIMEOUT + 1);
    logic [c_TW-1:0]     tmo_q, tmo_d;
    logic                rsp_err_q;
`endif

    assign req_ready = (state_q == IDLE) & ena;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        tmo_hit = 1'b0;
`ifdef TT_BRIDGE_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    asm_d   = '0;
                    cnt_d   = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                cnt_d   = '0;
                state_d = ADDR;
            end
            ADDR: begin
                if (cnt_q == c_CW'(c_NA - 1)) begin
                    cnt_d   = '0;
                    state_d = we_q ? WDATA : RDATA;
`ifdef TT_BRIDGE_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + c_CW'(1);
                end
            end
            WDATA: begin
                if (cnt_q == c_CW'(c_ND - 1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + c_CW'(1);
                end
            end
            RDATA: begin
                if (pin_in_valid) begin
                    // First byte received drifts up to the MSB as later bytes arrive.
                    asm_d = DATA_W'({asm_q, pin_in});
`ifdef TT_BRIDGE_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (cnt_q == c_CW'(c_ND - 1)) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + c_CW'(1);
                    end
                end else begin
`ifdef TT_BRIDGE_TIMEOUT_EN
                    tmo_d = tmo_q + c_TW'(1);
                    if (tmo_d == c_TW'(TIMEOUT)) begin
                        tmo_hit = 1'b1;
                        cnt_d   = '0;
                        state_d = RESP;
                    end
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        int sh;
        pin_strobe_d = 1'b0;
        pin_out_d    = 8'h00;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = '0;
        sh           = 0;
        case (state_d)
            HDR: begin
                pin_strobe_d = 1'b1;
                pin_out_d    = {we_d, 3'b000, c_HDR_LEN};
            end
            ADDR: begin
                sh           = 8 * (c_NA - 1 - int'(cnt_d));
                pin_strobe_d = 1'b1;
                pin_out_d    = 8'(addr_d >> sh);
            end
            WDATA: begin
                sh           = 8 * (c_ND - 1 - int'(cnt_d));
                pin_strobe_d = 1'b1;
                pin_out_d    = 8'(wdata_d >> sh);
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                if (!we_d && !tmo_hit) begin
                    rsp_rdata_d = asm_d;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            asm_q        <= '0;
            pin_out_q    <= 8'h00;
            pin_strobe_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            pin_out_q    <= pin_out_d;
            pin_strobe_q <= pin_strobe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

`ifdef TT_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            rsp_err_q <= tmo_hit;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign pin_out    = pin_out_q;
    assign pin_strobe = pin_strobe_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_mem_byte_bridge.sv
// ============================================================================
// Module  : tb_tt_mem_byte_bridge
// Purpose : Scoreboard bench for tt_mem_byte_bridge (32/16 and 8/8 instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_mem_byte_bridge;

    logic        clk;
    logic        rst_n;
    logic        ena;

    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  pin_out, pin_in;
    logic        pin_strobe, pin_in_valid;

    logic        req_valid8, req_ready8, req_we8;
    logic [7:0]  req_addr8, req_wdata8;
    logic        rsp_valid8, rsp_err8;
    logic [7:0]  rsp_rdata8;
    logic [7:0]  pin_out8;
    logic        pin_strobe8;

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } pin_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        e;
    } rsp_exp_t;

    pin_exp_t pin_q[$];
    rsp_exp_t rsp_q[$];
    pin_exp_t pin8_q[$];
    rsp_exp_t rsp8_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    tt_mem_byte_bridge #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .pin_out      (pin_out),
        .pin_strobe   (pin_strobe),
        .pin_in       (pin_in),
        .pin_in_valid (pin_in_valid)
    );

    tt_mem_byte_bridge #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .req_valid    (req_valid8),
        .req_ready    (req_ready8),
        .req_we       (req_we8),
        .req_addr     (req_addr8),
        .req_wdata    (req_wdata8),
        .rsp_valid    (rsp_valid8),
        .rsp_rdata    (rsp_rdata8),
        .rsp_err      (rsp_err8),
        .pin_out      (pin_out8),
        .pin_strobe   (pin_strobe8),
        .pin_in       (8'h00),
        .pin_in_valid (1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_main();
        pin_exp_t pe;
        rsp_exp_t re;
        forever begin
            @(negedge clk);
            if (pin_strobe) begin
                if (pin_q.size() == 0) begin
                    chk("pin_unexpected", {56'd0, pin_out}, 64'hFFFF);
                end else begin
                    pe = pin_q.pop_front();
                    chk("pin_byte", {56'd0, pin_out}, {56'd0, pe.b});
                    chk("pin_cycle", 64'(cyc), 64'(pe.cyc));
                end
            end else begin
                chk("pin_idle_zero", {56'd0, pin_out}, 64'd0);
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {32'd0, rsp_rdata}, 64'hFFFF_FFFF_FFFF);
                end else begin
                    re = rsp_q.pop_front();
                    chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, re.d});
                    chk("rsp_err", {63'd0, rsp_err}, {63'd0, re.e});
                    chk("rsp_cycle", 64'(cyc), 64'(re.cyc));
                end
            end
        end
    endtask

    task automatic mon_8();
        pin_exp_t pe;
        rsp_exp_t re;
        forever begin
            @(negedge clk);
            if (pin_strobe8) begin
                if (pin8_q.size() == 0) begin
                    chk("pin8_unexpected", {56'd0, pin_out8}, 64'hFFFF);
                end else begin
                    pe = pin8_q.pop_front();
                    chk("pin8_byte", {56'd0, pin_out8}, {56'd0, pe.b});
                    chk("pin8_cycle", 64'(cyc), 64'(pe.cyc));
                end
            end
            if (rsp_valid8) begin
                if (rsp8_q.size() == 0) begin
                    chk("rsp8_unexpected", {56'd0, rsp_rdata8}, 64'hFFFF);
                end else begin
                    re = rsp8_q.pop_front();
                    chk("rsp8_rdata", {56'd0, rsp_rdata8}, {32'd0, re.d});
                    chk("rsp8_err", {63'd0, rsp_err8}, {63'd0, re.e});
                    chk("rsp8_cycle", 64'(cyc), 64'(re.cyc));
                end
            end
        end
    endtask

    // Call at #1 after a rising edge; returns #1 after the edge ending the handshake cycle.
    task automatic do_req(input bit d8, input bit we, input logic [15:0] a,
                          input logic [31:0] wd, input bit keep, output int t);
        bit ok;
        ok = 1'b0;
        t  = -1;
        if (!d8) begin
            req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        end else begin
            req_valid8 = 1'b1; req_we8 = we; req_addr8 = a[7:0]; req_wdata8 = wd[7:0];
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (d8 ? req_ready8 : req_ready) begin
                ok = 1'b1;
                t  = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            chk("req_handshake_timeout", 64'd0, 64'd1);
        end else if (!d8) begin
            pin_q.push_back('{t + 1, {we, 3'b000, 4'd3}});
            pin_q.push_back('{t + 2, a[15:8]});
            pin_q.push_back('{t + 3, a[7:0]});
            if (we) begin
                pin_q.push_back('{t + 4, wd[31:24]});
                pin_q.push_back('{t + 5, wd[23:16]});
                pin_q.push_back('{t + 6, wd[15:8]});
                pin_q.push_back('{t + 7, wd[7:0]});
                rsp_q.push_back('{t + 8, 32'd0, 1'b0});
            end
        end else begin
            pin8_q.push_back('{t + 1, {we, 3'b000, 4'd0}});
            pin8_q.push_back('{t + 2, a[7:0]});
            if (we) begin
                pin8_q.push_back('{t + 3, wd[7:0]});
                rsp8_q.push_back('{t + 4, 32'd0, 1'b0});
            end
        end
        if (!keep || !ok) begin
            if (!d8) req_valid = 1'b0; else req_valid8 = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        pin_in       = b;
        pin_in_valid = 1'b1;
        step();
        pin_in_valid = 1'b0;
        pin_in       = 8'h00;
    endtask

    task automatic wait_until(input int c);
        for (int i = 0; i < 200 && cyc < c; i++) step();
    endtask

    initial begin
        int t, t2, b;
        rst_n = 1'b0; ena = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid8 = 1'b0; req_we8 = 1'b0; req_addr8 = '0; req_wdata8 = '0;
        pin_in = 8'h00; pin_in_valid = 1'b0;

        fork
            mon_main();
            mon_8();
        join_none

        // Reset state
        step(); step();
        chk("reset_pin_out", {56'd0, pin_out}, 64'd0);
        chk("reset_strobe", {63'd0, pin_strobe}, 64'd0);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", {63'd0, req_ready}, 64'd1);

        // Write 0x1234 <- 0xDEADBEEF: 83 12 34 DE AD BE EF, rsp at T+8
        do_req(1'b0, 1'b1, 16'h1234, 32'hDEAD_BEEF, 1'b0, t);
        wait_until(t + 10);

        // Read 0x00A0: header 03, 00, A0; bytes 01..04 with 2-cycle gaps
        do_req(1'b0, 1'b0, 16'h00A0, 32'd0, 1'b0, t);
        wait_until(t + 4);
        send_byte(8'h01); step(); step();
        send_byte(8'h02); step(); step();
        send_byte(8'h03); step(); step();
        b = cyc;
        send_byte(8'h04);
        rsp_q.push_back('{b + 1, 32'h0102_0304, 1'b0});
        wait_until(b + 4);

        // A byte landing on the cycle the idle count would reach 8 is kept
        do_req(1'b0, 1'b0, 16'h0102, 32'd0, 1'b0, t);
        wait_until(t + 4);
        send_byte(8'hAA);
        wait_until(t + 12);
        send_byte(8'hBB);
        send_byte(8'hCC);
        b = cyc;
        send_byte(8'hDD);
        rsp_q.push_back('{b + 1, 32'hAABB_CCDD, 1'b0});
        wait_until(b + 4);

`ifdef TT_BRIDGE_TIMEOUT_EN
        // Two bytes only: idle count hits 8 in the 8th idle cycle, error registers next cycle
        do_req(1'b0, 1'b0, 16'h0010, 32'd0, 1'b0, t);
        wait_until(t + 4);
        send_byte(8'h11);
        b = cyc;
        send_byte(8'h22);
        rsp_q.push_back('{b + 9, 32'd0, 1'b1});
        wait_until(b + 12);
`endif

        // Reset pulsed mid-RDATA: outputs clear at once, no response follows
        do_req(1'b0, 1'b0, 16'h5555, 32'd0, 1'b0, t);
        wait_until(t + 4);
        send_byte(8'h77);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_pin_out", {56'd0, pin_out}, 64'd0);
        chk("midrst_strobe", {63'd0, pin_strobe}, 64'd0);
        chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("midrst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("midrst_rsp_err", {63'd0, rsp_err}, 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("midrst_ready", {63'd0, req_ready}, 64'd1);
        for (int i = 0; i < 10; i++) step();

        // ena low blocks acceptance
        ena = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'hFFFF; req_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ready_ena_low", {63'd0, req_ready}, 64'd0);
            step();
        end
        req_valid = 1'b0;
        ena = 1'b1;
        step();

        // ena dropped mid-write: stream and response still complete
        do_req(1'b0, 1'b1, 16'hBEEF, 32'h1122_3344, 1'b0, t);
        ena = 1'b0;
        wait_until(t + 10);
        ena = 1'b1;
        step();

        // 8/8 instance: back-to-back writes, headers 5 cycles apart
        do_req(1'b1, 1'b1, 16'h005A, 32'h0000_00C3, 1'b1, t);
        do_req(1'b1, 1'b1, 16'h00A5, 32'h0000_003C, 1'b0, t2);
        chk("b2b_handshake_gap", 64'(t2), 64'(t + 5));
        wait_until(t2 + 6);

        for (int i = 0; i < 100 && (pin_q.size() + rsp_q.size() + pin8_q.size() + rsp8_q.size()) != 0; i++)
            step();
        chk("leftover_expectations", 64'(pin_q.size() + rsp_q.size() + pin8_q.size() + rsp8_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
